// File: rtl/apb_pkg.sv
// Shared types, widths and address-decode helper for the APB register-file slave.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} apb_state_e;

  // Word-aligned, inside the bank, and not a write to the read-only top register.
  function automatic logic addr_valid(input logic [APB_ADDR_W-1:0] addr,
                                      input logic                  is_write,
                                      input int unsigned           num_regs);
    logic [APB_ADDR_W-1:0] limit;
    logic [APB_ADDR_W-1:0] top_word;
    limit    = APB_ADDR_W'(num_regs * 4);
    top_word = APB_ADDR_W'(num_regs - 1);
    return (addr[1:0] == 2'b00) && (addr < limit) &&
           !(is_write && ((addr >> 2) == top_word));
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// 4-bit wait-state counter: load at setup, count down during the access phase.
module apb_wait_counter (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB register-file slave with programmable wait states; the top register counts committed writes.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [APB_DATA_W-1:0] reg0_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  apb_state_e state, next_state;

  logic [IDX_W-1:0]      lat_idx;
  logic                  lat_write;
  logic                  lat_err;
  logic [APB_DATA_W-1:0] lat_data;

  logic [APB_DATA_W-1:0] regs [NUM_REGS-1];
  logic [APB_DATA_W-1:0] wr_count;
  logic [APB_DATA_W-1:0] read_word;

  logic wc_load, wc_dec, wc_zero;
  logic setup, enter_done, commit;

  apb_wait_counter u_wait (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .load     (wc_load),
    .load_val (4'(WAIT_STATES)),
    .dec      (wc_dec),
    .zero     (wc_zero)
  );

  assign setup = (state == IDLE) && PSEL && !PENABLE;

  always_comb begin
    next_state = state;
    wc_load    = 1'b0;
    wc_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          wc_load    = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL)
          next_state = IDLE;
        else if (PENABLE) begin
          if (wc_zero) next_state = DONE;
          else         wc_dec     = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign enter_done = (state == ACCESS) && (next_state == DONE);
  assign commit     = (state == DONE) && lat_write && !lat_err;

  always_comb begin
    read_word = wr_count;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++)
      if (lat_idx == IDX_W'(i)) read_word = regs[i];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_data  <= '0;
    end else if (setup) begin
      lat_idx   <= PADDR[2 +: IDX_W];
      lat_write <= PWRITE;
      lat_err   <= !addr_valid(PADDR, PWRITE, NUM_REGS);
      lat_data  <= PWDATA;
    end
  end

  // Commit on the edge that ends DONE; the counter index can never be written here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_count <= '0;
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    end else if (commit) begin
      wr_count <= wr_count + 32'd1;
      for (int unsigned i = 0; i < NUM_REGS - 1; i++)
        if (lat_idx == IDX_W'(i)) regs[i] <= lat_data;
    end
  end

  // Response outputs are registered on entry to DONE so they are valid for exactly that cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= enter_done;
      PSLVERR <= enter_done && lat_err;
      PRDATA  <= (enter_done && !lat_write && !lat_err) ? read_word : '0;
    end
  end

  assign reg0_out = regs[0];

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one instance with one wait state, one with none.
module tb_apb_regfile_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        psel1 = 1'b0, psel0 = 1'b0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] prdata1, prdata0, reg0_1, reg0_0;
  logic        pready1, pready0, pslverr1, pslverr0;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(pslverr1), .reg0_out(reg0_1)
  );

  apb_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .reg0_out(reg0_0)
  );

  // Entered and left at posedge+1. lat counts cycles from setup to the PREADY cycle (-1 = timeout).
  task automatic xfer(input bit ws0, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, output int lat,
                      output logic [31:0] rdata, output logic err);
    lat = -1; rdata = '0; err = 1'b0;
    if (ws0) psel0 = 1'b1; else psel1 = 1'b1;
    PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = 32'hFFFF_FFF0; PWDATA = 32'h0BAD_0BAD;
    for (int k = 1; k <= 10; k++) begin
      @(negedge PCLK);
      if ((ws0 ? pready0 : pready1) === 1'b1) begin
        lat   = k;
        rdata = ws0 ? prdata0 : prdata1;
        err   = ws0 ? pslverr0 : pslverr1;
        break;
      end
    end
    @(posedge PCLK); #1;
    psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pready1 !== 1'b0 || pready0 !== 1'b0) begin errors++; $display("FAIL reset_pready got %b/%b want 0/0", pready1, pready0); end
    checks++; if (pslverr1 !== 1'b0 || pslverr0 !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b/%b want 0/0", pslverr1, pslverr0); end
    checks++; if (prdata1 !== 32'h0 || prdata0 !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h/%h want 0", prdata1, prdata0); end
    checks++; if (reg0_1 !== 32'h0 || reg0_0 !== 32'h0) begin errors++; $display("FAIL reset_reg0 got %h/%h want 0", reg0_1, reg0_0); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic err;
    xfer(0, 1, 32'h04, 32'hDEAD_BEEF, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr04_latency got %0d want 3", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr04_pslverr got %b want 0", err); end
    xfer(0, 0, 32'h04, 32'h0, lat, rd, err);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd04_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd04_data got %h want deadbeef", rd); end
    xfer(0, 1, 32'h00, 32'h11, lat, rd, err);
    checks++; if (reg0_1 !== 32'h11) begin errors++; $display("FAIL reg0_out got %h want 00000011", reg0_1); end
  endtask

  task automatic test_counter();
    int lat; logic [31:0] rd; logic err;
    do_reset();
    xfer(0, 1, 32'h08, 32'h1, lat, rd, err);
    xfer(0, 1, 32'h0C, 32'h2, lat, rd, err);
    xfer(0, 1, 32'h10, 32'h3, lat, rd, err);
    xfer(0, 0, 32'h1C, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL counter_after3 got %h want 00000003", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL counter_rd_err got %b want 0", err); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic err;
    xfer(0, 1, 32'h1C, 32'h55, lat, rd, err);
    checks++; if (err !== 1'b1 || lat !== 3) begin errors++; $display("FAIL wr1c_err got err=%b lat=%0d want err=1 lat=3", err, lat); end
    xfer(0, 1, 32'h20, 32'hAAAA_0001, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr20_err got %b want 1", err); end
    xfer(0, 1, 32'h06, 32'hAAAA_0002, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr06_err got %b want 1", err); end
    xfer(0, 0, 32'h20, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rd20 got err=%b data=%h want err=1 data=0", err, rd); end
    xfer(0, 0, 32'h1C, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL counter_after_errs got %h want 00000003", rd); end
    xfer(0, 0, 32'h04, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reg1_untouched got %h want 0", rd); end
    checks++; if (reg0_1 !== 32'h0) begin errors++; $display("FAIL reg0_untouched got %h want 0", reg0_1); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic err; int pulses;
    do_reset();
    psel1 = 1'b1; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'hCAFE; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    pulses = 0;
    @(negedge PCLK);
    if (pready1 === 1'b1) pulses++;
    psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (6) begin @(negedge PCLK); if (pready1 === 1'b1) pulses++; end
    @(posedge PCLK); #1;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_pready got %0d pulses want 0", pulses); end
    xfer(0, 0, 32'h08, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_reg2 got %h want 0", rd); end
    xfer(0, 0, 32'h1C, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_counter got %h want 0", rd); end
  endtask

  task automatic test_protocol();
    int lat; logic [31:0] rd; logic err; int pulses;
    psel1 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h1;
    pulses = 0;
    repeat (6) begin @(negedge PCLK); if (pready1 === 1'b1) pulses++; end
    @(posedge PCLK); #1;
    psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL nosetup_pready got %0d pulses want 0", pulses); end
    xfer(0, 0, 32'h1C, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0 || reg0_1 !== 32'h0) begin errors++; $display("FAIL nosetup_commit got cnt=%h reg0=%h want 0/0", rd, reg0_1); end
  endtask

  task automatic test_back_to_back();
    int lat_w, lat_r; logic [31:0] rd; logic err;
    xfer(0, 1, 32'h0C, 32'hA5, lat_w, rd, err);
    xfer(0, 0, 32'h0C, 32'h0, lat_r, rd, err);
    checks++; if (lat_w !== 3 || lat_r !== 3) begin errors++; $display("FAIL b2b_latency got %0d/%0d want 3/3", lat_w, lat_r); end
    checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL b2b_read got %h want 000000a5", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err;
    xfer(0, 1, 32'h00, 32'h99, lat, rd, err);
    checks++; if (reg0_1 !== 32'h99) begin errors++; $display("FAIL pre_reset_reg0 got %h want 00000099", reg0_1); end
    psel1 = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h77; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 32'h0 || reg0_1 !== 32'h0) begin
      errors++; $display("FAIL async_reset_outs got rdy=%b err=%b rd=%h reg0=%h want all 0", pready1, pslverr1, prdata1, reg0_1);
    end
    psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #3 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(0, 0, 32'h10, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg4 got %h want 0", rd); end
    xfer(0, 0, 32'h1C, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_counter got %h want 0", rd); end
  endtask

  task automatic test_ws0();
    int lat; logic [31:0] rd; logic err;
    xfer(1, 1, 32'h08, 32'h1234_5678, lat, rd, err);
    checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL ws0_write got lat=%0d err=%b want 2/0", lat, err); end
    xfer(1, 0, 32'h08, 32'h0, lat, rd, err);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ws0_read_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ws0_read_data got %h want 12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_counter();
    test_errors();
    test_abort();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    test_ws0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB slave directly downstream of the team's APB master: decodes PSEL/PENABLE/PWRITE/PADDR, inserts a programmable number of wait states, then completes each transfer with a one-cycle PREADY pulse.
- Holds a bank of 32-bit registers, returns PRDATA on reads and flags bad accesses with PSLVERR.
- The top register is a read-only counter of completed writes, which gives the bench an independent check on commit behaviour.

Parameters:
- NUM_REGS, 8, number of 32-bit registers. Power of two, at least 2. Index NUM_REGS-1 is the read-only write counter.
- WAIT_STATES, 1, number of cycles PREADY is held low in the access phase before completion. Range 0..15.

Ports:
- PCLK  in  1  clock; all logic on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.
- reg0_out  out  32  live value of register 0 (control output to the rest of the design).

Behaviour:
- Reset: async on PRESETn=0. State=IDLE, all registers 0, write counter 0, PREADY=0, PSLVERR=0, PRDATA=0, wait counter 0. Reset mid-transfer aborts the transfer with no commit.
- Address decode:
  - idx = PADDR[2 +: log2(NUM_REGS)].
  - Valid only if PADDR[1:0]==0 and PADDR < NUM_REGS*4.
  - A write to idx NUM_REGS-1 is an error.
- State machine (registered outputs):
  - IDLE: when PSEL=1 and PENABLE=0 (setup phase), latch addr, write flag, data and error flag, load wait_cnt=WAIT_STATES, go to ACCESS.
  - IDLE with PSEL=1 and PENABLE=1 (no setup phase): protocol violation; ignore and stay IDLE.
  - ACCESS, each cycle with PSEL=1 and PENABLE=1: if wait_cnt!=0, decrement it and keep PREADY=0. If wait_cnt==0, go to DONE.
  - DONE: PREADY=1 for exactly one cycle, then IDLE. If the next cycle is a new setup phase (PSEL=1, PENABLE=0), it is captured from IDLE as normal.
  - ACCESS with PSEL=0: abort; back to IDLE, no commit, PREADY stays 0.
- Latency: with the setup phase at cycle T, PREADY=1 in cycle T+2+WAIT_STATES. With WAIT_STATES=0 that is T+2, so the master sees one wait cycle minimum.
- Write commit: at the rising edge ending the DONE cycle, reg[idx] <= latched data and write counter += 1. The counter wraps 0xFFFFFFFF -> 0. On error, neither happens.
- Read: PRDATA = reg[idx] (or the counter for idx NUM_REGS-1) during the DONE cycle. PRDATA=0 in all other cycles and on read errors.
- PSLVERR = latched error flag during DONE; 0 otherwise.
- Address and data are latched at setup. Changes on PADDR/PWDATA during ACCESS are ignored.
- PREADY never stays high for two consecutive cycles.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - APB_DATA_W=32, APB_ADDR_W=32
  - function addr_valid(addr, is_write, num_regs)
- Sub-module apb_wait_counter: load / decrement / zero flag, 4-bit. Instanced once.
- Register bank and decode live in the top module.

Test Plan:
- WAIT_STATES=1, NUM_REGS=8:
  - Write 0xDEADBEEF to 0x04 -> PREADY=1 exactly 3 cycles after setup, PSLVERR=0. Read 0x04 -> PRDATA=0xDEADBEEF in the PREADY cycle.
  - Write 0x11 to 0x00 -> reg0_out=0x00000011 the cycle after PREADY.
  - Three valid writes, then read 0x1C -> PRDATA=0x00000003.
  - Write 0x55 to 0x1C -> PSLVERR=1, counter unchanged.
  - Write to 0x20 or to 0x06 -> PSLVERR=1 with PREADY, no register changes, PRDATA=0.
- WAIT_STATES=1, abort and protocol errors:
  - Write to 0x08 with PSEL dropped during the wait cycle -> PREADY never asserts, reg2 stays 0, counter unchanged.
  - PSEL=1 and PENABLE=1 with no setup phase -> no PREADY.
- WAIT_STATES=1, back-to-back and reset:
  - Back-to-back write 0xA5 to 0x0C then read 0x0C -> two separate one-cycle PREADY pulses, read returns 0xA5.
  - PRESETn low during ACCESS of a write to 0x10 -> all outputs 0 immediately (async), reg4 stays 0 after release.
- WAIT_STATES=0: write then read 0x08 -> PREADY 2 cycles after each setup, data correct.
